// File: rtl/loop_seq_pkg.sv
// Shared types for the loop sequencer: FSM state encoding and the
// body_lat value that selects handshake pacing.
package loop_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int MODE_HANDSHAKE = 0;

endpackage

// File: rtl/lat_counter.sv
// Loadable down-counter that paces fixed-latency loop bodies; last flags
// the final wait cycle (value == 1).
module lat_counter #(
    parameter int LAT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    input  logic             en,
    output logic             last
);

    logic [LAT_W-1:0] value;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (en && value != '0) begin
            value <= value - LAT_W'(1);
        end
    end

    assign last = (value == LAT_W'(1));

endmodule

// File: rtl/loop_sequencer.sv
// N-iteration start/done loop controller: issues one iter_valid per
// iteration, paced by a fixed latency or by body_ack, with abort support.
module loop_sequencer
    import loop_seq_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int LAT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [CNT_W-1:0] n_iter,
    input  logic [LAT_W-1:0] body_lat,
    input  logic             body_ack,
    input  logic             abort,
    output logic             iter_valid,
    output logic [CNT_W-1:0] iter_idx,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] done_count
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] n_reg;
    logic [CNT_W-1:0] idx_reg;
    logic [CNT_W-1:0] count_reg;
    logic [LAT_W-1:0] lat_reg;
    logic             aborted_reg;
    logic             accept;
    logic             hs_mode;
    logic             last_iter;
    logic             wait_exit;
    logic             cnt_load;
    logic             cnt_en;
    logic             cnt_last;

    assign start_ready = (state == IDLE) && !rst;
    assign accept      = start_valid && start_ready;
    assign hs_mode     = (lat_reg == LAT_W'(MODE_HANDSHAKE));
    // n_reg is at least 1 whenever WAIT is reachable, so n-1 never underflows.
    assign last_iter   = (idx_reg == n_reg - CNT_W'(1));
    assign wait_exit   = (state == WAIT) && (hs_mode ? body_ack : cnt_last);

    lat_counter #(.LAT_W(LAT_W)) u_lat_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (lat_reg),
        .en       (cnt_en),
        .last     (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt  = state;
        iter_valid = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = (n_iter == '0) ? DONE : ISSUE;
            end
            ISSUE: begin
                iter_valid = 1'b1;
                busy       = 1'b1;
                cnt_load   = 1'b1;
                state_nxt  = abort ? DONE : WAIT;
            end
            WAIT: begin
                busy   = 1'b1;
                cnt_en = 1'b1;
                if (abort)          state_nxt = DONE;
                else if (wait_exit) state_nxt = last_iter ? DONE : ISSUE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Abort takes priority over a same-cycle iteration exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_reg       <= '0;
            lat_reg     <= '0;
            idx_reg     <= '0;
            count_reg   <= '0;
            aborted_reg <= 1'b0;
        end else if (accept) begin
            n_reg       <= n_iter;
            lat_reg     <= body_lat;
            idx_reg     <= '0;
            count_reg   <= '0;
            aborted_reg <= 1'b0;
        end else if ((state == ISSUE || state == WAIT) && abort) begin
            aborted_reg <= 1'b1;
        end else if (wait_exit) begin
            count_reg <= count_reg + CNT_W'(1);
            if (!last_iter) idx_reg <= idx_reg + CNT_W'(1);
        end
    end

    assign iter_idx   = idx_reg;
    assign done_count = count_reg;
    assign aborted    = aborted_reg;

endmodule

// File: tb/tb_loop_sequencer.sv
// Self-checking bench for loop_sequencer: directed and random jobs compared
// cycle by cycle against an event schedule computed from the loop rules.
module tb_loop_sequencer;

    localparam int CNT_W = 16;
    localparam int LAT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start_valid = 1'b0;
    logic             body_ack = 1'b0;
    logic             abort = 1'b0;
    logic [CNT_W-1:0] n_iter = '0;
    logic [LAT_W-1:0] body_lat = '0;
    logic             start_ready, iter_valid, busy, done, aborted;
    logic [CNT_W-1:0] iter_idx, done_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    loop_sequencer #(.CNT_W(CNT_W), .LAT_W(LAT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .n_iter      (n_iter),
        .body_lat    (body_lat),
        .body_ack    (body_ack),
        .abort       (abort),
        .iter_valid  (iter_valid),
        .iter_idx    (iter_idx),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .done_count  (done_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one job. lat==0 selects handshake mode: each WAIT lasts hs_wait
    // cycles (random 1..4 when hs_wait==0) and ack is also raised in ISSUE.
    // abort_cyc is the cycle (relative to accept) in which abort is driven.
    task automatic run_job(input int n, input int lat, input int abort_cyc, input int hs_wait);
        int issue_c[$];
        int exit_c[$];
        int done_cyc, exp_cnt, exp_last, s, w, k;
        bit exp_ab, busy_e, iv_e;
        s = 1; exp_cnt = 0; exp_last = 0; exp_ab = 0; done_cyc = 0;
        if (n == 0) done_cyc = 1;
        for (int i = 0; i < n && done_cyc == 0; i++) begin
            w = (lat != 0) ? lat : ((hs_wait != 0) ? hs_wait : int'($urandom_range(1, 4)));
            issue_c.push_back(s);
            exit_c.push_back(s + w);
            exp_last = i;
            if (abort_cyc >= s && abort_cyc <= s + w) begin
                done_cyc = abort_cyc + 1;
                exp_ab   = 1'b1;
            end else begin
                exp_cnt = i + 1;
                s       = s + w + 1;
            end
        end
        if (done_cyc == 0) done_cyc = s;

        @(negedge clk);
        check("idle_ready", 32'(start_ready), 32'd1);
        start_valid = 1'b1;
        n_iter      = CNT_W'(n);
        body_lat    = LAT_W'(lat);
        abort       = 1'($urandom_range(0, 1));
        body_ack    = 1'($urandom_range(0, 1));
        k = 0;
        for (int c = 1; c <= done_cyc; c++) begin
            @(negedge clk);
            start_valid = 1'b0;
            n_iter      = CNT_W'($urandom);
            body_lat    = LAT_W'($urandom);
            while (k + 1 < issue_c.size() && issue_c[k+1] <= c) k++;
            busy_e = (c < done_cyc);
            iv_e   = busy_e && (issue_c[k] == c);
            check("iter_valid", 32'(iter_valid), 32'(iv_e));
            check("busy", 32'(busy), 32'(busy_e));
            check("done", 32'(done), 32'(c == done_cyc));
            check("ready_busy", 32'(start_ready), 32'd0);
            if (busy_e) check("iter_idx", 32'(iter_idx), 32'(k));
            if (c == done_cyc) begin
                check("done_idx", 32'(iter_idx), 32'(exp_last));
                check("done_count", 32'(done_count), 32'(exp_cnt));
                check("aborted", 32'(aborted), 32'(exp_ab));
            end
            abort = (c == abort_cyc) || (c == done_cyc && $urandom_range(0, 1) == 1);
            if (lat != 0) body_ack = 1'($urandom_range(0, 1));
            else          body_ack = busy_e && (exit_c[k] == c || issue_c[k] == c);
        end
        @(negedge clk);
        abort    = 1'b0;
        body_ack = 1'b0;
        check("post_ready", 32'(start_ready), 32'd1);
        check("post_done", 32'(done), 32'd0);
        check("post_busy", 32'(busy), 32'd0);
        check("hold_count", 32'(done_count), 32'(exp_cnt));
        check("hold_aborted", 32'(aborted), 32'(exp_ab));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, lat, ab;

        // Reset behaviour
        repeat (3) begin
            @(negedge clk);
            check("rst_ready", 32'(start_ready), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_iter_valid", 32'(iter_valid), 32'd0);
        end
        check("rst_idx", 32'(iter_idx), 32'd0);
        check("rst_count", 32'(done_count), 32'd0);
        check("rst_aborted", 32'(aborted), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_release_ready", 32'(start_ready), 32'd1);

        // Directed jobs
        run_job(3, 2, 0, 0);
        run_job(0, 5, 0, 0);
        run_job(2, 0, 0, 3);
        run_job(5, 1, 6, 0);
        run_job(65535, 1, 5, 0);
        run_job(1, 255, 0, 0);
        run_job(4, 0, 0, 1);

        // Reset in WAIT of iteration 1 (n=3, L=2: ISSUE idx1 at cycle 4)
        @(negedge clk);
        start_valid = 1'b1;
        n_iter      = 16'd3;
        body_lat    = 8'd2;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start_valid = 1'b0;
        end
        check("pre_rst_busy", 32'(busy), 32'd1);
        check("pre_rst_idx", 32'(iter_idx), 32'd1);
        check("pre_rst_count", 32'(done_count), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", 32'(start_ready), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_iter_valid", 32'(iter_valid), 32'd0);
        check("mid_rst_idx", 32'(iter_idx), 32'd0);
        check("mid_rst_count", 32'(done_count), 32'd0);
        check("mid_rst_aborted", 32'(aborted), 32'd0);
        rst = 1'b0;
        #1;
        check("mid_rst_release_ready", 32'(start_ready), 32'd1);
        @(negedge clk);
        check("no_done_after_rst", 32'(done), 32'd0);
        run_job(1, 1, 0, 0);

        // start_valid held high: accepts only in IDLE, one done per 4 cycles
        @(negedge clk);
        start_valid = 1'b1;
        n_iter      = 16'd1;
        body_lat    = 8'd1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            check("held_done", 32'(done), 32'((c % 4) == 3));
            check("held_ready", 32'(start_ready), 32'((c % 4) == 0));
            check("held_iter_valid", 32'(iter_valid), 32'((c % 4) == 1));
        end
        start_valid = 1'b0;
        check("held_count", 32'(done_count), 32'd1);
        repeat (2) @(negedge clk);

        // Random jobs
        for (int j = 0; j < 30; j++) begin
            n   = int'($urandom_range(0, 6));
            lat = int'($urandom_range(0, 3));
            ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, n * 5 + 1)) : 0;
            run_job(n, lat, ab, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/loop_sequencer.md
# loop_sequencer

Parametrised start/done controller generalising the plain idle/busy/done handshake FSM into an N-iteration loop sequencer for compiled C `for` loops. Accepts a job (iteration count plus body latency), issues one `iter_valid` pulse per iteration with its index, and paces iterations by a fixed latency or by a body acknowledge. Supports abort and reports the completed iteration count. It sits between the top-level job FSM and a generated loop-body datapath.

## Interface
Parameters:
- `CNT_W`, 16: width of iteration count/index.
- `LAT_W`, 8: width of body latency field.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-high.
- `start_valid`  in  1  job request.
- `start_ready`  out  1  high only in IDLE and while `rst` low.
- `n_iter`  in  CNT_W  iteration count, sampled on accept.
- `body_lat`  in  LAT_W  0 = handshake mode; L≥1 = fixed L wait cycles per iteration; sampled on accept.
- `body_ack`  in  1  body completion, handshake mode only.
- `abort`  in  1  terminate current job.
- `iter_valid`  out  1  one-cycle pulse per iteration (ISSUE state).
- `iter_idx`  out  CNT_W  current iteration index, 0-based, stable ISSUE through WAIT.
- `busy`  out  1  high in ISSUE or WAIT.
- `done`  out  1  one-cycle pulse (DONE state).
- `aborted`  out  1  valid with `done`: job ended by abort.
- `done_count`  out  CNT_W  valid with `done`: iterations whose WAIT completed.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: accept on `start_valid && start_ready`; latch `n_iter`, `body_lat`; clear idx, count, aborted. `n_iter==0` → DONE; else → ISSUE.
- ISSUE: `iter_valid=1`; load wait counter with `body_lat`; → WAIT.
- WAIT, fixed mode: down-count L cycles; exits on the cycle the counter reads 1. Handshake mode: exits on first cycle `body_ack`=1 (ack during ISSUE ignored). On exit: count+1; if idx==n_iter−1 → DONE, else idx+1 → ISSUE.
- DONE: `done=1` one cycle; → IDLE. `aborted`, `done_count` hold until next accept.
- `abort` in ISSUE/WAIT: → DONE next edge, `aborted=1`, count not incremented for the interrupted iteration; abort beats `body_ack`/counter exit on same cycle. `abort` in IDLE/DONE ignored.
- `n_iter` up to 2^CNT_W−1; idx never wraps (compare against n−1 only when n≥1).
- `rst` any state, mid-job included: → IDLE; idx, count, counter, `aborted` cleared; no `done` pulse.
- Reset values: `start_ready`=0 during rst then 1; `iter_valid`, `busy`, `done`, `aborted`=0; `iter_idx`, `done_count`=0.

## Timing
- Accept at edge E0 (cycle 0). First ISSUE in cycle 1.
- Fixed mode: iteration period L+1 cycles; ISSUE k at cycle 1+k(L+1); DONE at cycle N(L+1)+1; `start_ready` again at N(L+1)+2.
- `n_iter==0`: DONE at cycle 1, `done_count`=0.
- Handshake mode: WAIT lasts until ack, minimum 1 cycle; back-to-back acks give period 2.
- All outputs are registered state decodes; no combinational path from inputs to outputs except `start_ready` gated by `rst`.

## Structure
- `loop_seq_pkg`: 2-bit state enum typedef (IDLE=0, ISSUE=1, WAIT=2, DONE=3), and MODE_HANDSHAKE constant (body_lat value 0).
- Sub-module `lat_counter`: loadable LAT_W down-counter with `load`, `en`, `last` (value==1) outputs.

## Test plan
- `n_iter`=3, `body_lat`=2 → `iter_valid` at cycles 1,4,7 with idx 0,1,2; `done` at cycle 10, `done_count`=3, `aborted`=0.
- `n_iter`=0 → `done` at cycle 1, `done_count`=0, no `iter_valid`.
- `body_lat`=0, `n_iter`=2, `body_ack` high during ISSUE then 3 cycles later in WAIT → ack in ISSUE ignored, exit on WAIT ack; `done_count`=2.
- `n_iter`=5, `body_lat`=1, `abort` in WAIT of idx 2 coincident with counter exit → `done` next cycle, `aborted`=1, `done_count`=2.
- `rst` asserted in WAIT of idx 1 → next cycle IDLE, all outputs 0, no `done`; new job with `n_iter`=1 completes with `done_count`=1.
- `start_valid` held high continuously with `n_iter`=1, `body_lat`=1 → jobs accepted only in IDLE; one `done` per 4 cycles.
